// File: rtl/cmul_pkg.sv
// Shared types and constants for the complex twiddle-multiply sequencer.
package cmul_pkg;

  localparam int CMUL_N    = 16;
  localparam int CMUL_FRAC = 14;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_ROUND = 3'd3,
    ST_OUT   = 3'd4
  } cmul_state_t;

  typedef logic [1:0] cmul_idx_t;

  // Signed saturation bounds for an n-bit result
  function automatic longint sat_max(input int n);
    return (64'sd1 <<< (n - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_min(input int n);
    return -(64'sd1 <<< (n - 1));
  endfunction

  localparam longint CMUL_SAT_MAX = sat_max(CMUL_N);
  localparam longint CMUL_SAT_MIN = sat_min(CMUL_N);

endpackage

// File: rtl/cmul_round_sat.sv
// Combinational scale-down of a 2N+1-bit accumulator to an N-bit saturated result.
// CMUL_ROUND_EN selects round-half-up; otherwise a floor (truncating) shift.
module cmul_round_sat
  import cmul_pkg::*;
#(
  parameter int     N       = CMUL_N,
  parameter int     FRAC    = CMUL_FRAC,
  parameter longint SAT_MAX = CMUL_SAT_MAX,
  parameter longint SAT_MIN = CMUL_SAT_MIN
) (
  input  logic signed [2*N:0] i_acc,
  output logic signed [N-1:0] o_y
);

  // One guard bit so the rounding add can never wrap
  localparam int W = 2 * N + 2;
  localparam logic signed [W-1:0] L_MAX = SAT_MAX[W-1:0];
  localparam logic signed [W-1:0] L_MIN = SAT_MIN[W-1:0];
`ifdef CMUL_ROUND_EN
  localparam longint              HALF   = 64'sd1 <<< (FRAC - 1);
  localparam logic signed [W-1:0] L_HALF = HALF[W-1:0];
`endif

  logic signed [W-1:0] w_ext;
  logic signed [W-1:0] w_sum;
  logic signed [W-1:0] w_shift;

  // Round (optional), arithmetic shift, then clamp to the N-bit range
  always_comb begin
    w_ext = {i_acc[2*N], i_acc};
`ifdef CMUL_ROUND_EN
    w_sum = w_ext + L_HALF;
`else
    w_sum = w_ext;
`endif
    w_shift = w_sum >>> FRAC;
    if (w_shift > L_MAX) begin
      o_y = L_MAX[N-1:0];
    end else if (w_shift < L_MIN) begin
      o_y = L_MIN[N-1:0];
    end else begin
      o_y = w_shift[N-1:0];
    end
  end

endmodule

// File: rtl/cmul_sequencer.sv
// Complex multiply y = x*w using one shared sequential multiplier for four real products.
// Rounding mode of the result is selected by CMUL_ROUND_EN (see cmul_round_sat).
module cmul_sequencer
  import cmul_pkg::*;
#(
  parameter int N    = CMUL_N,
  parameter int FRAC = CMUL_FRAC
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  input  logic signed [N-1:0]   i_x_re,
  input  logic signed [N-1:0]   i_x_im,
  input  logic signed [N-1:0]   i_w_re,
  input  logic signed [N-1:0]   i_w_im,
  output logic                  o_mul_ld,
  output logic signed [N-1:0]   o_mul_m,
  output logic signed [N-1:0]   o_mul_r,
  input  logic                  i_mul_valid,
  input  logic signed [2*N-1:0] i_mul_p,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic signed [N-1:0]   o_y_re,
  output logic signed [N-1:0]   o_y_im,
  output logic                  o_busy
);

  localparam logic signed [N-1:0] L_ZERO_N = {N{1'b0}};
  localparam logic signed [2*N:0] L_ZERO_A = {(2*N+1){1'b0}};

  cmul_state_t        r_state;
  cmul_idx_t          r_k;
  logic signed [N-1:0] r_x_re, r_x_im, r_w_re, r_w_im;
  logic signed [2*N:0] r_acc_re, r_acc_im;
  logic               r_in_ready, r_mul_ld, r_out_valid, r_busy;
  logic signed [N-1:0] r_mul_m, r_mul_r, r_y_re, r_y_im;

  cmul_idx_t           w_k_nxt;
  logic signed [N-1:0] w_op_m, w_op_r;
  logic signed [2*N:0] w_p_ext;
  logic signed [N-1:0] w_y_re, w_y_im;

  assign w_p_ext = {i_mul_p[2*N-1], i_mul_p};

  // Operand pair for the next product index, taken from the latched sample/twiddle
  always_comb begin
    w_k_nxt = r_k + 2'd1;
    w_op_m  = r_x_re;
    w_op_r  = r_w_re;
    case (w_k_nxt)
      2'd0:    begin w_op_m = r_x_re; w_op_r = r_w_re; end
      2'd1:    begin w_op_m = r_x_im; w_op_r = r_w_im; end
      2'd2:    begin w_op_m = r_x_re; w_op_r = r_w_im; end
      2'd3:    begin w_op_m = r_x_im; w_op_r = r_w_re; end
      default: begin w_op_m = r_x_re; w_op_r = r_w_re; end
    endcase
  end

  cmul_round_sat #(.N(N), .FRAC(FRAC), .SAT_MAX(sat_max(N)), .SAT_MIN(sat_min(N))) u_rs_re (
    .i_acc (r_acc_re),
    .o_y   (w_y_re)
  );

  cmul_round_sat #(.N(N), .FRAC(FRAC), .SAT_MAX(sat_max(N)), .SAT_MIN(sat_min(N))) u_rs_im (
    .i_acc (r_acc_im),
    .o_y   (w_y_im)
  );

  // Sequencer FSM with accumulators and registered outputs; mul_ld is raised on entry to ISSUE
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_k         <= 2'd0;
      r_x_re      <= L_ZERO_N;
      r_x_im      <= L_ZERO_N;
      r_w_re      <= L_ZERO_N;
      r_w_im      <= L_ZERO_N;
      r_acc_re    <= L_ZERO_A;
      r_acc_im    <= L_ZERO_A;
      r_in_ready  <= 1'b1;
      r_mul_ld    <= 1'b0;
      r_mul_m     <= L_ZERO_N;
      r_mul_r     <= L_ZERO_N;
      r_out_valid <= 1'b0;
      r_y_re      <= L_ZERO_N;
      r_y_im      <= L_ZERO_N;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_in_valid) begin
            r_x_re     <= i_x_re;
            r_x_im     <= i_x_im;
            r_w_re     <= i_w_re;
            r_w_im     <= i_w_im;
            r_acc_re   <= L_ZERO_A;
            r_acc_im   <= L_ZERO_A;
            r_k        <= 2'd0;
            r_mul_ld   <= 1'b1;
            r_mul_m    <= i_x_re;
            r_mul_r    <= i_w_re;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_mul_ld <= 1'b0;
          r_state  <= ST_WAIT;
        end
        ST_WAIT: begin
          if (i_mul_valid) begin
            case (r_k)
              2'd0:    r_acc_re <= r_acc_re + w_p_ext;
              2'd1:    r_acc_re <= r_acc_re - w_p_ext;
              default: r_acc_im <= r_acc_im + w_p_ext;
            endcase
            if (r_k != 2'd3) begin
              r_k      <= w_k_nxt;
              r_mul_ld <= 1'b1;
              r_mul_m  <= w_op_m;
              r_mul_r  <= w_op_r;
              r_state  <= ST_ISSUE;
            end else begin
              r_state  <= ST_ROUND;
            end
          end
        end
        ST_ROUND: begin
          r_y_re      <= w_y_re;
          r_y_im      <= w_y_im;
          r_out_valid <= 1'b1;
          r_state     <= ST_OUT;
        end
        ST_OUT: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_mul_ld    <= 1'b0;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_mul_ld    = r_mul_ld;
  assign o_mul_m     = r_mul_m;
  assign o_mul_r     = r_mul_r;
  assign o_out_valid = r_out_valid;
  assign o_y_re      = r_y_re;
  assign o_y_im      = r_y_im;
  assign o_busy      = r_busy;

endmodule
